rs_issue_pick: RTL

//   Issue selector for the reservation station. Collects per-entry issue requests
//   and packets from the NUM_ENTRIES rs_entry instances, picks the oldest ready entry

---
 rtl/rs_issue_pick.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rs_issue_pick.sv
// Reservation-station issue selector: age-matrix oldest-ready pick, one-hot grant,
// and the rs2 issue register handed to execute over a valid/ready handshake.

package rs_issue_pick_pkg;
    typedef struct packed {
        logic       valid;
    } t_nuke_pkt;

    typedef struct packed {
        logic [5:0]  robid;
        logic [3:0]  uop;
        logic [15:0] data;
    } t_iss_pkt;
endpackage

// Handshake: iss_pkt_rs2 transfers to execute in any cycle where iss_valid_rs2 and
// ex_ready_rs2 are both high; while valid is high without ready, valid and packet hold.
module rs_issue_pick
    import rs_issue_pick_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  t_nuke_pkt              nuke_rb1,
    input  logic [NUM_ENTRIES-1:0] e_alloc_rs0,
    input  logic [NUM_ENTRIES-1:0] e_req_issue_rs1,
    input  t_iss_pkt               e_issue_pkt_rs1 [NUM_ENTRIES],
    output logic [NUM_ENTRIES-1:0] e_gnt_issue_rs1,
    output logic                   iss_valid_rs2,
    output t_iss_pkt               iss_pkt_rs2,
    input  logic                   ex_ready_rs2,
    output logic [CNT_W-1:0]       cnt_issued
);

    // r_age[i][j] = 1: entry i is older than entry j
    logic [NUM_ENTRIES-1:0] r_age     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_age_nxt [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_older   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_win;
    logic [NUM_ENTRIES-1:0] w_gnt;
    t_iss_pkt               w_win_pkt;
    logic                   w_slot_free;
    logic                   w_transfer;
    logic                   w_any_gnt;

    logic                   r_iss_valid;
    t_iss_pkt               r_iss_pkt;
    logic [CNT_W-1:0]       r_cnt_issued;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_age_nxt[i] = r_age[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (i == j) begin
                    w_age_nxt[i][j] = 1'b0;
                end else if (e_alloc_rs0[i] && e_alloc_rs0[j]) begin
                    w_age_nxt[i][j] = (i < j);
                end else if (e_alloc_rs0[i]) begin
                    w_age_nxt[i][j] = 1'b0;
                end else if (e_alloc_rs0[j]) begin
                    w_age_nxt[i][j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_age[i] <= w_age_nxt[i];
            end
        end
    end

    // Pairs with no recorded age (never allocated since reset) fall back to index
    // order, so any two requesters always have exactly one older of the pair.
    always_comb begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
            w_older[j] = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (i != j) begin
                    w_older[j][i] = r_age[j][i] | (~r_age[i][j] & (j < i));
                end
            end
        end
    end

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != i) begin
                    blocked = blocked | (e_req_issue_rs1[j] & w_older[j][i]);
                end
            end
            w_win[i] = e_req_issue_rs1[i] & ~blocked;
        end
    end

    always_comb begin
        w_win_pkt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_win[i]) begin
                w_win_pkt = w_win_pkt | e_issue_pkt_rs1[i];
            end
        end
    end

    assign w_slot_free     = ~r_iss_valid | ex_ready_rs2;
    assign w_gnt           = w_win & {NUM_ENTRIES{w_slot_free & ~nuke_rb1.valid & ~reset}};
    assign w_any_gnt       = |w_gnt;
    assign w_transfer      = r_iss_valid & ex_ready_rs2 & ~nuke_rb1.valid;
    assign e_gnt_issue_rs1 = w_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_valid <= 1'b0;
            r_iss_pkt   <= '0;
        end else begin
            if (nuke_rb1.valid) begin
                r_iss_valid <= 1'b0;
            end else if (w_any_gnt) begin
                r_iss_valid <= 1'b1;
            end else if (ex_ready_rs2) begin
                r_iss_valid <= 1'b0;
            end
            if (w_any_gnt) begin
                r_iss_pkt <= w_win_pkt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_issued <= '0;
        end else if (w_transfer) begin
            r_cnt_issued <= r_cnt_issued + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign iss_valid_rs2 = r_iss_valid;
    assign iss_pkt_rs2   = r_iss_pkt;
    assign cnt_issued    = r_cnt_issued;

`ifdef ASSERT
    logic w_age_conflict;
    always_comb begin
        w_age_conflict = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (i != j) begin
                    w_age_conflict = w_age_conflict | (r_age[i][j] & r_age[j][i]);
                end
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(e_gnt_issue_rs1));
    a_gnt_has_req: assert property (@(posedge clk) (e_gnt_issue_rs1 & ~e_req_issue_rs1) == '0);
    a_alloc_no_req: assert property (@(posedge clk) disable iff (reset)
        (e_alloc_rs0 & e_req_issue_rs1) == '0);
    a_age_antisym: assert property (@(posedge clk) disable iff (reset) !w_age_conflict);
`endif

endmodule
